// File: rtl/mvau_deadlock_watchdog.sv
// rtl/mvau_deadlock_watchdog.sv - block-persistence deadlock watchdog with one-shot report
// Optional event counter port/logic: MVAU_DEADLOCK_EVENT_CNT_EN
module mvau_deadlock_watchdog #(
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             block,
    input  logic [2:0]       axis_block_sigs,
    input  logic [1:0]       inst_idle_sigs,
    input  logic             clear,
    output logic             deadlock,
    output logic [2:0]       deadlock_axis,
    output logic [CNT_W-1:0] block_cycles,
    output logic             rpt_valid,
    output logic [7:0]       rpt_data,
    input  logic             rpt_ready
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
    ,
    output logic [15:0]      event_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        REPORT  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             fire;

    assign cnt_inc = block_cycles + CNT_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = block_cycles;
        fire    = 1'b0;
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE, SUSPECT: begin
                    if (block) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == THR) begin
                            state_n = REPORT;
                            fire    = 1'b1;
                        end else begin
                            state_n = SUSPECT;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                REPORT: begin
                    if (rpt_ready) state_n = HOLD;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            block_cycles  <= '0;
            deadlock      <= 1'b0;
            deadlock_axis <= '0;
            rpt_valid     <= 1'b0;
            rpt_data      <= '0;
        end else begin
            state        <= state_n;
            block_cycles <= cnt_n;
            if (clear) begin
                deadlock      <= 1'b0;
                deadlock_axis <= '0;
                rpt_valid     <= 1'b0;
                rpt_data      <= '0;
            end else if (fire) begin
                deadlock      <= 1'b1;
                deadlock_axis <= axis_block_sigs;
                rpt_valid     <= 1'b1;
                rpt_data      <= {3'b000, inst_idle_sigs, axis_block_sigs};
            end else if (state == REPORT && rpt_ready) begin
                // Report word is kept after acceptance; only valid drops.
                rpt_valid <= 1'b0;
            end
        end
    end

`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            event_count <= '0;
        end else if (fire && event_count != 16'hFFFF) begin
            event_count <= event_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvau_deadlock_watchdog.sv
// tb/tb_mvau_deadlock_watchdog.sv - vector table plus report scoreboard for mvau_deadlock_watchdog
module tb_mvau_deadlock_watchdog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // THRESHOLD=4 instance
    logic        rst4, blk4, clr4, rdy4;
    logic [2:0]  axis4;
    logic [1:0]  idle4;
    logic        dl4, rv4;
    logic [2:0]  da4;
    logic [15:0] bc4;
    logic [7:0]  rd4;

    // THRESHOLD=1 instance
    logic        rst1, blk1, clr1, rdy1;
    logic [2:0]  axis1;
    logic [1:0]  idle1;
    logic        dl1, rv1;
    logic [2:0]  da1;
    logic [15:0] bc1;
    logic [7:0]  rd1;
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
    logic [15:0] ec4, ec1;
`endif

    mvau_deadlock_watchdog #(.THRESHOLD(4), .CNT_W(16)) u_dut4 (
        .clock(clk), .reset(rst4), .block(blk4), .axis_block_sigs(axis4),
        .inst_idle_sigs(idle4), .clear(clr4), .deadlock(dl4), .deadlock_axis(da4),
        .block_cycles(bc4), .rpt_valid(rv4), .rpt_data(rd4), .rpt_ready(rdy4)
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        , .event_count(ec4)
`endif
    );

    mvau_deadlock_watchdog #(.THRESHOLD(1), .CNT_W(16)) u_dut1 (
        .clock(clk), .reset(rst1), .block(blk1), .axis_block_sigs(axis1),
        .inst_idle_sigs(idle1), .clear(clr1), .deadlock(dl1), .deadlock_axis(da1),
        .block_cycles(bc1), .rpt_valid(rv1), .rpt_data(rd1), .rpt_ready(rdy1)
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        , .event_count(ec1)
`endif
    );

    typedef struct {
        logic        blk, clr, rdy;
        logic [2:0]  axis;
        logic [1:0]  idle;
        logic        dl, rv, chkd;
        logic [2:0]  da;
        logic [15:0] bc;
        logic [7:0]  rd;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic vec_t mk(input logic blk, input logic clr, input logic rdy,
                                input logic [2:0] axis, input logic [1:0] idle,
                                input logic dl, input logic rv, input logic chkd,
                                input logic [2:0] da, input logic [15:0] bc,
                                input logic [7:0] rd);
        vec_t v;
        v.blk = blk; v.clr = clr; v.rdy = rdy; v.axis = axis; v.idle = idle;
        v.dl = dl; v.rv = rv; v.chkd = chkd; v.da = da; v.bc = bc; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic prev_rv;
        logic [7:0] exp_rd;

        rst4 = 0; blk4 = 0; clr4 = 0; rdy4 = 0; axis4 = 0; idle4 = 0;
        rst1 = 0; blk1 = 0; clr1 = 0; rdy1 = 0; axis1 = 0; idle1 = 0;

        // blk clr rdy axis idle | dl rv chkd da bc rd
        vecs.push_back(mk(1,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd1,8'h00));
        vecs.push_back(mk(1,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd2,8'h00));
        vecs.push_back(mk(1,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd3,8'h00));
        vecs.push_back(mk(0,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(0,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(1,0,0,3'd5,2'd2, 0,0,1,3'd0,16'd1,8'h00));
        vecs.push_back(mk(1,0,0,3'd5,2'd2, 0,0,1,3'd0,16'd2,8'h00));
        vecs.push_back(mk(1,0,0,3'd5,2'd2, 0,0,1,3'd0,16'd3,8'h00));
        vecs.push_back(mk(1,0,0,3'd5,2'd2, 1,1,1,3'd5,16'd4,8'h15));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1,0,0,3'd2,2'd1, 1,1,1,3'd5,16'd4,8'h15));
        vecs.push_back(mk(1,0,1,3'd0,2'd0, 1,0,0,3'd5,16'd4,8'h00));
        vecs.push_back(mk(1,0,1,3'd0,2'd0, 1,0,0,3'd5,16'd4,8'h00));
        vecs.push_back(mk(0,0,0,3'd0,2'd0, 1,0,0,3'd5,16'd4,8'h00));
        vecs.push_back(mk(0,0,0,3'd0,2'd0, 1,0,0,3'd5,16'd4,8'h00));
        vecs.push_back(mk(0,1,1,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(1,1,0,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(1,0,0,3'd3,2'd1, 0,0,1,3'd0,16'd1,8'h00));
        vecs.push_back(mk(1,0,0,3'd3,2'd1, 0,0,1,3'd0,16'd2,8'h00));
        vecs.push_back(mk(1,0,0,3'd3,2'd1, 0,0,1,3'd0,16'd3,8'h00));
        vecs.push_back(mk(1,0,0,3'd3,2'd1, 1,1,1,3'd3,16'd4,8'h0B));
        vecs.push_back(mk(0,1,1,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(0,0,1,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(1,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd1,8'h00));
        vecs.push_back(mk(1,1,0,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));
        vecs.push_back(mk(1,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd1,8'h00));
        vecs.push_back(mk(0,0,0,3'd0,2'd0, 0,0,1,3'd0,16'd0,8'h00));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst4 = 1; rst1 = 1;

        chk("reset_deadlock", 32'(dl4), 32'd0);
        chk("reset_rpt_valid", 32'(rv4), 32'd0);
        chk("reset_block_cycles", 32'(bc4), 32'd0);
        chk("reset_rpt_data", 32'(rd4), 32'd0);
        chk("reset_deadlock_axis", 32'(da4), 32'd0);
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        chk("reset_event_count", 32'(ec4), 32'd0);
`endif

        prev_rv = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            blk4 = vecs[i].blk; clr4 = vecs[i].clr; rdy4 = vecs[i].rdy;
            axis4 = vecs[i].axis; idle4 = vecs[i].idle;
            if (vecs[i].rv && !prev_rv) sb.push_back({3'b000, vecs[i].idle, vecs[i].axis});
            prev_rv = vecs[i].rv;
            #1;
            if (rv4 && rdy4) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_report", 32'(rd4), 32'hFFFF_FFFF);
                end else begin
                    exp_rd = sb.pop_front();
                    chk("sb_report_word", 32'(rd4), 32'(exp_rd));
                end
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_deadlock", i), 32'(dl4), 32'(vecs[i].dl));
            chk($sformatf("v%0d_rpt_valid", i), 32'(rv4), 32'(vecs[i].rv));
            chk($sformatf("v%0d_block_cycles", i), 32'(bc4), 32'(vecs[i].bc));
            chk($sformatf("v%0d_deadlock_axis", i), 32'(da4), 32'(vecs[i].da));
            if (vecs[i].chkd)
                chk($sformatf("v%0d_rpt_data", i), 32'(rd4), 32'(vecs[i].rd));
        end
        chk("sb_pending_reports", 32'(sb.size()), 32'd0);

        // THRESHOLD=1: a single blocked cycle declares
        @(negedge clk);
        blk1 = 1; axis1 = 3'b110; idle1 = 2'b11;
        @(posedge clk); #1;
        chk("t1_deadlock", 32'(dl1), 32'd1);
        chk("t1_rpt_valid", 32'(rv1), 32'd1);
        chk("t1_block_cycles", 32'(bc1), 32'd1);
        chk("t1_rpt_data", 32'(rd1), 32'h1E);
        chk("t1_deadlock_axis", 32'(da1), 32'd6);
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        chk("t1_event_count_1", 32'(ec1), 32'd1);
`endif
        @(negedge clk);
        blk1 = 0; clr1 = 1; rdy1 = 1;
        @(posedge clk); #1;
        chk("t1_clear_deadlock", 32'(dl1), 32'd0);
        chk("t1_clear_rpt_valid", 32'(rv1), 32'd0);
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        chk("t1_clear_keeps_event_count", 32'(ec1), 32'd1);
`endif
        @(negedge clk);
        clr1 = 0; rdy1 = 0; blk1 = 1;
        @(posedge clk); #1;
        chk("t1_second_deadlock", 32'(dl1), 32'd1);
        chk("t1_second_rpt_valid", 32'(rv1), 32'd1);
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        chk("t1_event_count_2", 32'(ec1), 32'd2);
`endif
        // Reset while a report is pending
        @(negedge clk);
        blk1 = 0; rst1 = 0;
        @(posedge clk); #1;
        chk("t1_rst_rpt_valid", 32'(rv1), 32'd0);
        chk("t1_rst_deadlock", 32'(dl1), 32'd0);
        chk("t1_rst_block_cycles", 32'(bc1), 32'd0);
`ifdef MVAU_DEADLOCK_EVENT_CNT_EN
        chk("t1_rst_event_count", 32'(ec1), 32'd0);
`endif
        @(negedge clk);
        rst1 = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvau_deadlock_watchdog.md
# mvau_deadlock_watchdog

Downstream consumer of the per-instance HLS deadlock monitor's `block` output for an MVAU layer. Filters transient block indications by requiring THRESHOLD consecutive blocked cycles before declaring a deadlock. On a declared deadlock it latches a sticky flag and a snapshot of the AXI-stream and instance-idle signals. It then delivers a one-shot report word over a valid/ready handshake to the simulation logging sink.

## Interface
- THRESHOLD, 1024: consecutive `block`=1 cycles required to declare deadlock; legal range 1 .. 2^CNT_W-1.
- CNT_W, 16: width of the consecutive-block counter.
- clock  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of `clock`).
- block  input  1  monitor's registered block indication.
- axis_block_sigs  input  3  per-AXI-stream block signals, same as fed to the monitor.
- inst_idle_sigs  input  2  per-instance idle signals, same as fed to the monitor.
- clear  input  1  one-cycle re-arm request.
- deadlock  output  1  sticky deadlock flag.
- deadlock_axis  output  3  `axis_block_sigs` snapshot at declaration.
- block_cycles  output  CNT_W  current consecutive-block count.
- rpt_valid  output  1  report word valid.
- rpt_data  output  8  report word: [2:0] axis snapshot, [4:3] idle snapshot, [7:5] 3'b000.
- rpt_ready  input  1  sink accepts report.
- event_count  output  16  number of declared deadlocks. Present only when MVAU_DEADLOCK_EVENT_CNT_EN is defined.

## Operation
- States are IDLE, SUSPECT, REPORT and HOLD. Reset state is IDLE.
- Reset values: deadlock=0, deadlock_axis=0, block_cycles=0, rpt_valid=0, rpt_data=0, event_count=0.
- Counting rule: on each edge with `block`=1 in IDLE/SUSPECT, next = block_cycles+1. When next equals THRESHOLD, the FSM enters REPORT on that same edge.
- IDLE:
  - `block`=0: stay IDLE, count stays 0.
  - `block`=1: go to SUSPECT with count=1, or directly to REPORT if THRESHOLD=1.
- SUSPECT:
  - `block`=0: go to IDLE, count cleared to 0.
  - `block`=1: increment; go to REPORT when the counting rule fires.
- Entering REPORT, all on one edge:
  - set deadlock=1.
  - latch deadlock_axis and rpt_data from the `axis_block_sigs`/`inst_idle_sigs` sampled on that edge.
  - set rpt_valid=1.
  - increment event_count (saturates at 16'hFFFF).
- REPORT: rpt_valid and rpt_data are held stable until rpt_ready=1. The handshake completes on the edge where rpt_valid&rpt_ready, and the FSM moves to HOLD with rpt_valid=0.
- HOLD: deadlock stays 1 regardless of `block`. Exactly one report is issued per declaration.
- In REPORT/HOLD, block_cycles freezes at THRESHOLD. `block` is ignored.
- clear:
  - In any state, `clear`=1 sends the FSM to IDLE and clears block_cycles, deadlock, rpt_valid and deadlock_axis.
  - clear has priority over counting and over the handshake. Clear together with rpt_ready in REPORT counts as consumed; no re-report follows.
  - event_count is not affected by clear.
- clear together with `block`=1 in IDLE: result is IDLE with count 0. Counting resumes on the next edge.
- Reset asserted mid-report drops rpt_valid without a handshake. This is permitted.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Declaration latency: deadlock/rpt_valid are visible the cycle after the edge that samples the THRESHOLD-th consecutive `block`=1.
- Clear latency: outputs return to their reset values the cycle after the `clear` edge.
- rpt_valid may only fall after a handshake, a clear or a reset.

## Configuration
- MVAU_DEADLOCK_EVENT_CNT_EN defined:
  - `event_count` port and its 16-bit saturating counter exist.
  - The counter is cleared only by reset.
- Undefined: port and counter are absent. All other behaviour is identical.

## Test plan
- THRESHOLD=4, `block`=1 for 3 cycles then 0 -> deadlock stays 0, block_cycles goes 1,2,3,0, rpt_valid never rises.
- THRESHOLD=4, `block`=1 continuously, axis_block_sigs=3'b101, inst_idle_sigs=2'b10:
  - 4th edge -> next cycle deadlock=1, deadlock_axis=3'b101, rpt_data=8'h15, rpt_valid=1, block_cycles=4.
- Hold rpt_ready=0 for 5 cycles then 1 -> rpt_valid and rpt_data stable throughout, rpt_valid=0 after the accept edge, deadlock stays 1, no second report.
- After declaration drop `block` to 0 -> deadlock stays 1. Then pulse clear together with rpt_ready -> next cycle all outputs are 0 and the FSM is in IDLE.
- THRESHOLD=1, single-cycle `block`=1 -> deadlock=1 the next cycle. With MVAU_DEADLOCK_EVENT_CNT_EN, event_count=1; after clear and a second declaration, event_count=2.
- Drive reset=0 while rpt_valid=1 -> next cycle rpt_valid=0, deadlock=0, event_count=0.
